// File: rtl/uart_tx_block.sv
// UART-style serial transmitter: start bit, LSB-first data,
// optional even parity, one or two stop bits, valid/ready input.
module uart_tx_block #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_done
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] D_MAX = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] S_MAX = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_state;
  logic [TW-1:0]          r_tmr;
  logic [TW-1:0]          w_tmr;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          w_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   w_shift;
  logic                   r_par;
  logic                   w_par;
  logic                   r_ser;
  logic                   w_ser;
  logic                   r_done;
  logic                   w_done;
  logic                   w_wrap;

  assign w_wrap     = (r_tmr == T_MAX);
  assign tx_ready   = (r_state == S_IDLE);
  assign serial_out = r_ser;
  assign tx_done    = r_done;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_shift <= '1;
      r_par   <= 1'b0;
      r_ser   <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tmr   <= w_tmr;
      r_idx   <= w_idx;
      r_shift <= w_shift;
      r_par   <= w_par;
      r_ser   <= w_ser;
      r_done  <= w_done;
    end
  end

  // Line value is computed for the next state so it is registered
  // and only moves on bit boundaries.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_shift = r_shift;
    w_par   = r_par;
    w_ser   = r_ser;
    w_done  = 1'b0;
    w_tmr   = (r_state == S_IDLE || w_wrap) ? '0 : r_tmr + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        w_ser = 1'b1;
        if (tx_valid) begin
          w_state = S_START;
          w_shift = tx_data;
          w_par   = ^tx_data;
          w_ser   = 1'b0;
          w_idx   = '0;
        end
      end
      S_START: begin
        if (w_wrap) begin
          w_state = S_DATA;
          w_ser   = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (r_idx == D_MAX) begin
            w_idx = '0;
            if (PARITY_EN != 0) begin
              w_state = S_PARITY;
              w_ser   = r_par;
            end else begin
              w_state = S_STOP;
              w_ser   = 1'b1;
            end
          end else begin
            w_idx   = r_idx + 1'b1;
            w_shift = {1'b1, r_shift[DATA_BITS-1:1]};
            w_ser   = r_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_state = S_STOP;
          w_ser   = 1'b1;
          w_idx   = '0;
        end
      end
      S_STOP: begin
        w_ser = 1'b1;
        if (w_wrap) begin
          if (r_idx == S_MAX) begin
            w_state = S_IDLE;
            w_done  = 1'b1;
            w_idx   = '0;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state = S_IDLE;
        w_ser   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Scoreboard bench: three parity/stop configurations run side by
// side, each with its own driver, reference queue and line monitor.
module tb_uart_tx_block;

  localparam int CPB = 10;

  typedef struct {
    logic [7:0] d;
    int         k;
  } fr_t;

  logic clk;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   n_fin;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int P  = (g == 0) ? 0 : 1;
    localparam int S  = (g == 2) ? 2 : 1;
    localparam int NB = 1 + 8 + P + S;
    localparam int FC = NB * CPB;

    logic       rn;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       ser;
    logic       done;
    fr_t        q[$];

    uart_tx_block #(
      .DATA_BITS   (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (P),
      .STOP_BITS   (S)
    ) u_dut (
      .clk       (clk),
      .n_rst     (rn),
      .tx_data   (data),
      .tx_valid  (valid),
      .tx_ready  (ready),
      .serial_out(ser),
      .tx_done   (done)
    );

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] d, input bit hold);
      bit ok;
      fr_t f;
      ok    = 1'b0;
      data  = d;
      valid = 1'b1;
      for (int i = 0; i < 5000 && !ok; i++) begin
        if (ready) begin
          ok  = 1'b1;
          f.d = d;
          f.k = cyc + 1;
          q.push_back(f);
        end
        @(negedge clk);
      end
      if (!ok) chk($sformatf("cfg%0d ready timeout", g), 0, 1);
      if (!hold || !ok) valid = 1'b0;
    endtask

    initial begin : drv
      int k;
      rn    = 1'b0;
      data  = 8'h00;
      valid = 1'b0;
      repeat (3) @(negedge clk);
      chk($sformatf("cfg%0d reset ser", g), int'(ser), 1);
      chk($sformatf("cfg%0d reset ready", g), int'(ready), 1);
      chk($sformatf("cfg%0d reset done", g), int'(done), 0);
      rn = 1'b1;
      repeat (2) @(negedge clk);
      if (g == 0) begin
        send(8'hA5, 1'b0);
        repeat (FC + 3) @(negedge clk);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b0);
        repeat (FC + 3) @(negedge clk);
        send(8'hA5, 1'b0);
        repeat (25) @(negedge clk);
        data  = 8'h3C;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (FC + 3) @(negedge clk);
        send(8'hA5, 1'b0);
        repeat (45) @(negedge clk);
        #2 rn = 1'b0;
        #1;
        chk("cfg0 async rst ser", int'(ser), 1);
        chk("cfg0 async rst ready", int'(ready), 1);
        chk("cfg0 async rst done", int'(done), 0);
        repeat (3) @(negedge clk);
        #2 rn = 1'b1;
        @(negedge clk);
        send(8'h55, 1'b0);
        repeat (FC + 3) @(negedge clk);
      end else if (g == 1) begin
        send(8'h07, 1'b0);
        repeat (FC + 3) @(negedge clk);
      end else begin
        send(8'hA5, 1'b0);
        repeat (FC + 3) @(negedge clk);
      end
      for (int n = 0; n < 20; n++) begin
        bit h;
        h = (n < 19) ? bit'($urandom_range(0, 1)) : 1'b0;
        send(8'($urandom), h);
        if (!h) repeat ($urandom_range(0, 5)) @(negedge clk);
      end
      repeat (FC + 5) @(negedge clk);
      chk($sformatf("cfg%0d frames left", g), q.size(), 0);
      n_fin++;
    end

    initial begin : mon
      forever begin
        @(negedge clk);
        if (rn && !ser) begin
          if (q.size() == 0) begin
            chk($sformatf("cfg%0d unexpected frame", g), 1, 0);
            repeat (FC - 1) @(negedge clk);
          end else begin
            fr_t f;
            logic [15:0] eb;
            int bad;
            int rbad;
            int dbad;
            int c0;
            bit abort;
            f     = q.pop_front();
            c0    = cyc;
            bad   = 0;
            rbad  = 0;
            dbad  = 0;
            abort = 1'b0;
            eb    = '1;
            eb[0] = 1'b0;
            for (int i = 0; i < 8; i++) eb[1 + i] = f.d[i];
            if (P != 0) eb[9] = ($countones(f.d) % 2 == 1);
            for (int b = 0; b < NB && !abort; b++) begin
              for (int c = 0; c < CPB && !abort; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!rn) abort = 1'b1;
                else begin
                  if (ser !== eb[b]) bad++;
                  if (ready !== 1'b0) rbad++;
                  if (done !== 1'b0) dbad++;
                end
              end
            end
            if (abort) q.delete();
            else begin
              chk($sformatf("cfg%0d start cyc d=%h", g, f.d), c0, f.k);
              chk($sformatf("cfg%0d bits d=%h", g, f.d), bad, 0);
              chk($sformatf("cfg%0d busy ready d=%h", g, f.d), rbad, 0);
              chk($sformatf("cfg%0d early done d=%h", g, f.d), dbad, 0);
              @(negedge clk);
              if (rn) begin
                chk($sformatf("cfg%0d done pulse", g), int'(done), 1);
                chk($sformatf("cfg%0d ready back", g), int'(ready), 1);
                chk($sformatf("cfg%0d idle gap", g), int'(ser), 1);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    n_fin   = 0;
    cyc     = 0;
    for (int i = 0; i < 60000 && n_fin < 3; i++) @(negedge clk);
    if (n_fin < 3) chk("global timeout", n_fin, 3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
